seg7_scan_ctrl: RTL and testbench

- Time-multiplexed controller for a bank of common-anode 7-segment digits that share one segment bus.
- Holds one 4-bit hex value and one decimal-point bit per digit. Scans the digits at a programmable rate.
- Adds global blanking (display off), per-digit enable and PWM brightness.
- Sits between the board-level user logic (counters, switches) and the display pins, and contains the hex-to-segment decoder.

---
 rtl/seg7_scan_ctrl.sv | 118 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: scans a bank of common-anode 7-segment digits that share one
// segment bus, with per-digit enable, global blanking and PWM brightness.
module seg7_scan_ctrl #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(NDIG)-1:0]   wr_addr,
  input  logic [3:0]                wr_data,
  input  logic                      wr_dp,
  input  logic                      blank_all,
  input  logic [NDIG-1:0]           dig_en,
  input  logic [PWM_BITS-1:0]       bright,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NDIG-1:0]           an,
  output logic [$clog2(NDIG)-1:0]   slot,
  output logic                      frame_done
);

  localparam int unsigned SW = $clog2(NDIG);
  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] pwm;
  logic [3:0]          val [NDIG];
  logic [NDIG-1:0]     dpv;

  logic                tick_c;
  logic                last_slot_c;
  logic                wr_ok_c;
  logic                on_c;
  logic [6:0]          dec_c;

  // Slot timing, write qualification and the per-cycle digit on-condition
  always_comb begin
    tick_c      = 1'b0;
    last_slot_c = 1'b0;
    wr_ok_c     = 1'b0;
    on_c        = 1'b0;
    tick_c      = (presc == PW'(TICK_DIV - 1));
    last_slot_c = (slot == SW'(NDIG - 1));
    wr_ok_c     = wr_en && (32'(wr_addr) < NDIG);
    // presc == 0 is the dead cycle at the start of each slot (anti-ghosting)
    on_c        = dig_en[slot] && !blank_all && (presc != '0) &&
                  ((pwm < bright) || (bright == '1));
  end

  // Hex-to-segment decode of the digit in the current slot (g..a, active-low)
  always_comb begin
    dec_c = 7'h7F;
    case (val[slot])
      4'h0:    dec_c = 7'b1000000;
      4'h1:    dec_c = 7'b1111001;
      4'h2:    dec_c = 7'b0100100;
      4'h3:    dec_c = 7'b0110000;
      4'h4:    dec_c = 7'b0011001;
      4'h5:    dec_c = 7'b0010010;
      4'h6:    dec_c = 7'b0000010;
      4'h7:    dec_c = 7'b1111000;
      4'h8:    dec_c = 7'b0000000;
      4'h9:    dec_c = 7'b0010000;
      4'hA:    dec_c = 7'b0001000;
      4'hB:    dec_c = 7'b0000011;
      4'hC:    dec_c = 7'b1000110;
      4'hD:    dec_c = 7'b0100001;
      4'hE:    dec_c = 7'b0000110;
      default: dec_c = 7'b0001110;
    endcase
  end

  // Prescaler, slot counter, frame pulse and free-running PWM counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      slot       <= '0;
      pwm        <= '0;
      frame_done <= 1'b0;
    end else begin
      presc      <= tick_c ? '0 : presc + PW'(1);
      pwm        <= pwm + PWM_BITS'(1);
      frame_done <= tick_c && last_slot_c;
      if (tick_c) begin
        slot <= last_slot_c ? '0 : slot + SW'(1);
      end
    end
  end

  // Digit register file; out-of-range addresses leave every entry untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NDIG); i++) begin
        val[i] <= '0;
      end
      dpv <= '0;
    end else if (wr_ok_c) begin
      val[wr_addr] <= wr_data;
      dpv[wr_addr] <= wr_dp;
    end
  end

  // Registered pin stage: one clock from counter/register state to the pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= on_c ? dec_c : 7'h7F;
      dp  <= on_c ? ~dpv[slot] : 1'b1;
      an  <= on_c ? ~(NDIG'(1) << slot) : '1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: cycle model plus directed checks.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int TD = 4;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       blank_all;
  logic [3:0] dig_en;
  logic [3:0] bright;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [1:0] slot;
  logic       frame_done;

  logic       wr_en3;
  logic [1:0] wr_addr3;
  logic [2:0] dig_en3;
  logic [6:0] seg3;
  logic       dp3;
  logic [2:0] an3;
  logic [1:0] slot3;
  logic       frame_done3;

  int nvec;
  int nerr;
  logic chk_en;

  seg7_scan_ctrl #(.NDIG(4), .TICK_DIV(4), .PWM_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .blank_all(blank_all),
    .dig_en(dig_en), .bright(bright), .seg(seg), .dp(dp), .an(an),
    .slot(slot), .frame_done(frame_done)
  );

  seg7_scan_ctrl #(.NDIG(3), .TICK_DIV(4), .PWM_BITS(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_addr(wr_addr3),
    .wr_data(wr_data), .wr_dp(wr_dp), .blank_all(blank_all),
    .dig_en(dig_en3), .bright(bright), .seg(seg3), .dp(dp3), .an(an3),
    .slot(slot3), .frame_done(frame_done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: time since reset release gives prescaler, slot and PWM phase directly
  int         n;
  int         mp;
  int         ms;
  int         mw;
  bit         mon;
  int         mval [ND];
  logic       mdp  [ND];
  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_an;
  logic [1:0] e_slot;
  logic       e_fd;

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      for (int i = 0; i < ND; i++) begin
        mval[i] = 0;
        mdp[i]  = 1'b0;
      end
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_slot = 2'd0; e_fd = 1'b0;
    end else begin
      mp  = n % TD;
      ms  = (n / TD) % ND;
      mw  = n % 16;
      mon = dig_en[ms] && !blank_all && (mp != 0) &&
            ((mw < int'(bright)) || (bright == 4'hF));
      e_seg = mon ? seg_tab[mval[ms]] : 7'h7F;
      e_dp  = mon ? !mdp[ms] : 1'b1;
      for (int i = 0; i < ND; i++) e_an[i] = !(mon && (i == ms));
      e_fd  = (mp == TD - 1) && (ms == ND - 1);
      if (wr_en && (int'(wr_addr) < ND)) begin
        mval[wr_addr] = int'(wr_data);
        mdp[wr_addr]  = wr_dp;
      end
      n++;
      e_slot = 2'((n / TD) % ND);
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("an", 32'(an), 32'(e_an));
      chk("slot", 32'(slot), 32'(e_slot));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  // Called on a falling edge; the write lands on the next rising edge
  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Land on the first falling edge after the slot counter enters slot s
  task automatic wait_slot(input logic [1:0] s);
    int k;
    k = 0;
    while (slot == s && k < 100) begin @(negedge clk); k++; end
    while (slot != s && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) chk("wait_slot_timeout", 32'(slot), 32'(s));
  endtask

  task automatic wait_an(input logic [3:0] pat, input string nm);
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (an != pat && k < 64);
    if (k >= 64) chk(nm, 32'(an), 32'(pat));
  endtask

  int fdc, onc, c0, c3, cdead, cdp, cbad;
  int s0, s1, s2;

  initial begin
    nvec = 0; nerr = 0; chk_en = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0;
    blank_all = 1'b0; dig_en = 4'hF; bright = 4'h0;
    wr_en3 = 1'b0; wr_addr3 = '0; dig_en3 = 3'h7;

    // Reset held: dark outputs
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_slot", 32'(slot), 32'h0);

    // Release with BRIGHT = 0: slot advances every 4 edges, nothing lit
    @(negedge clk);
    rst_n = 1'b1;
    fdc = 0; onc = 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (frame_done) fdc++;
      if (an != 4'hF) onc++;
      if (k == 3) chk("slot_k3", 32'(slot), 32'd0);
      if (k == 4) chk("slot_k4", 32'(slot), 32'd1);
      if (k == 8) chk("slot_k8", 32'(slot), 32'd2);
    end
    chk("frame_pulses_32", 32'(fdc), 32'd2);
    chk("bright0_lit", 32'(onc), 32'd0);

    // Load 1,2,3,F then full brightness
    @(negedge clk);
    wr(2'd0, 4'h1, 1'b1);
    wr(2'd1, 4'h2, 1'b0);
    wr(2'd2, 4'h3, 1'b1);
    wr(2'd3, 4'hF, 1'b0);
    bright = 4'hF;
    c0 = 0; c3 = 0; cdead = 0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      if (an == 4'b1110) begin c0++; chk("slot0_seg", 32'(seg), 32'b1111001); end
      if (an == 4'b0111) begin c3++; chk("slot3_seg", 32'(seg), 32'b0001110); end
      if (an == 4'hF) cdead++;
    end
    chk("slot0_cycles", 32'(c0), 32'd6);
    chk("slot3_cycles", 32'(c3), 32'd6);
    chk("dead_cycles", 32'(cdead), 32'd8);

    // BRIGHT = 4: lit only while pwm phase is 1..3 (phase 0 is a dead cycle)
    @(negedge clk);
    bright = 4'h4;
    onc = 0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (an != 4'hF) onc++;
    end
    chk("bright4_on", 32'(onc), 32'd12);

    // Blank mid-slot 2
    @(negedge clk);
    bright = 4'hF;
    wait_slot(2'd2);
    @(negedge clk);
    blank_all = 1'b1;
    @(posedge clk); #1;
    chk("blank_seg", 32'(seg), 32'h7F);
    chk("blank_an", 32'(an), 32'hF);
    chk("blank_dp", 32'(dp), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("blank_slot_runs", 32'(slot), 32'd3);
    @(negedge clk);
    blank_all = 1'b0;
    wait_an(4'b1011, "unblank_timeout");
    chk("unblank_seg", 32'(seg), 32'b0110000);

    // Write 8 to the active slot 3: new value on the edge after the write edge
    @(negedge clk);
    wait_slot(2'd3);
    wr(2'd3, 4'h8, 1'b0);
    @(posedge clk); #1;
    chk("active_wr_seg", 32'(seg), 32'b0000000);
    chk("active_wr_an", 32'(an), 32'b0111);

    // DIG_EN = 1010: only digits 1 and 3 light, DP only on digit 1
    @(negedge clk);
    wr(2'd1, 4'h2, 1'b1);
    dig_en = 4'b1010;
    onc = 0; cdp = 0; cbad = 0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      if (an != 4'hF) onc++;
      if (!an[0] || !an[2]) cbad++;
      if (!dp) begin cdp++; chk("dp_digit", 32'(an), 32'b1101); end
    end
    chk("en1010_on", 32'(onc), 32'd12);
    chk("en1010_bad", 32'(cbad), 32'd0);
    chk("en1010_dp", 32'(cdp), 32'd6);

    // NDIG = 3: address 3 is out of range and must not alter digits 0..2
    @(negedge clk);
    dig_en = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wr_en3 = 1'b1; wr_addr3 = 2'(i); wr_data = 4'(5 + i); wr_dp = 1'b0;
      if (i == 3) wr_data = 4'h8;
      @(negedge clk);
    end
    wr_en3 = 1'b0;
    s0 = 0; s1 = 0; s2 = 0; cbad = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (an3 == 3'b110) begin s0++; chk("n3_d0", 32'(seg3), 32'b0010010); end
      if (an3 == 3'b101) begin s1++; chk("n3_d1", 32'(seg3), 32'b0000010); end
      if (an3 == 3'b011) begin s2++; chk("n3_d2", 32'(seg3), 32'b1111000); end
      if (seg3 == 7'b0000000) cbad++;
    end
    chk("n3_lit", 32'(s0 + s1 + s2), 32'd18);
    chk("n3_no8", 32'(cbad), 32'd0);

    // Reset during a write: write aborted, digit 0 reads back as 0
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h8;
    @(negedge clk);
    wr_en = 1'b0; rst_n = 1'b1;
    wait_an(4'b1110, "rst_abort_timeout");
    chk("rst_abort_seg", 32'(seg), 32'b1000000);

    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
